picosoc_iomem_arbiter: RTL

Two-master arbiter and bus watchdog for the PicoSoC iomem bus. It sits between the PicoRV32 CPU (master 0) and a secondary master (master 1, e.g. a block-copy or debug-loader engine) on one side, and the shared peripheral-decode iomem bus (SRAM, UART, GPIO, SDRAM, SD card, A2FPGA registers) on the other. It grants the bus round-robin, one transaction at a time. It terminates any transaction the addressed peripheral fails to complete within a bounded time.

---
 rtl/picosoc_iomem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/picosoc_iomem_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC iomem bus, with a watchdog
// that force-completes transactions the addressed peripheral never acknowledges.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for a request; arbitrates and latches it
// ACCESS | request driven on the peripheral bus
// RESP   | one-cycle completion pulse to the granted master

module picosoc_iomem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,

   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,

   output logic        s_valid,
   output logic        s_instr,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,

   output logic        grant_o,
   output logic        timeout_o,
   output logic [31:0] timeout_addr_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        last_grant;
   logic [15:0] cnt;
   logic        pick_m1;
   logic        done;
   logic [31:0] done_data;

   // On contention the master that did not own the previous transaction wins.
   assign pick_m1 = m1_valid & (~m0_valid | ~last_grant);

   // Completion of the current ACCESS, either by the peripheral or by the watchdog.
   assign done      = s_ready | (cnt == CNT_LAST);
   assign done_data = s_ready ? s_rdata : TIMEOUT_RDATA;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= ST_IDLE;
         last_grant     <= 1'b1;
         cnt            <= '0;
         grant_o        <= 1'b0;
         s_valid        <= 1'b0;
         s_instr        <= 1'b0;
         s_wstrb        <= '0;
         s_addr         <= '0;
         s_wdata        <= '0;
         m0_ready       <= 1'b0;
         m1_ready       <= 1'b0;
         m0_rdata       <= '0;
         m1_rdata       <= '0;
         timeout_o      <= 1'b0;
         timeout_addr_o <= '0;
      end else begin
         m0_ready  <= 1'b0;
         m1_ready  <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         timeout_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (m0_valid || m1_valid) begin
                  grant_o    <= pick_m1;
                  last_grant <= pick_m1;
                  s_instr    <= pick_m1 ? m1_instr : m0_instr;
                  s_wstrb    <= pick_m1 ? m1_wstrb : m0_wstrb;
                  s_addr     <= pick_m1 ? m1_addr  : m0_addr;
                  s_wdata    <= pick_m1 ? m1_wdata : m0_wdata;
                  s_valid    <= 1'b1;
                  cnt        <= '0;
                  state      <= ST_ACCESS;
               end
            end

            ST_ACCESS: begin
               if (done) begin
                  s_valid <= 1'b0;
                  state   <= ST_RESP;
                  if (grant_o) begin
                     m1_ready <= 1'b1;
                     m1_rdata <= done_data;
                  end else begin
                     m0_ready <= 1'b1;
                     m0_rdata <= done_data;
                  end
                  if (!s_ready) begin
                     timeout_o      <= 1'b1;
                     timeout_addr_o <= s_addr;
                  end
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
            end

            ST_RESP: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
